// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: loads the instruction memory while idle,
// then steps FETCH/DECODE/EXEC/WB until a halt opcode is decoded.
module cpu_sequencer #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [3:0]  HALT_OP    = 4'hF
) (
    input  logic        clka,
    input  logic        reset_in,
    input  logic        we_ins,
    input  logic [15:0] load,
    input  logic        run,
    input  logic [15:0] imem_rdata,
    input  logic        br_taken,
    input  logic [5:0]  br_target,
    input  logic        we_reg_dec,
    output logic [5:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        imem_we,
    output logic [15:0] instr,
    output logic [5:0]  pc,
    output logic        we_reg,
    output logic        full,
    output logic        halted,
    output logic        ld_reject
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] LAST = 6'(IMEM_DEPTH - 1);

    state_t      r_state;
    logic [5:0]  r_pc;
    logic [5:0]  r_load_ptr;
    logic [15:0] r_instr;
    logic        r_full;
    logic        r_rej;
    logic        r_br_taken;
    logic [5:0]  r_br_target;

    logic        w_idle;
    logic        w_wr;
    logic        w_start;

    assign w_idle  = (r_state == S_IDLE) || (r_state == S_HALT);
    // Gated by reset so the write strobe drops the instant reset asserts.
    assign w_wr    = reset_in && w_idle && we_ins && !r_full;
    assign w_start = w_idle && run && !we_ins;

    assign imem_addr  = w_idle ? r_load_ptr : r_pc;
    assign imem_wdata = load;
    assign imem_we    = w_wr;
    assign instr      = r_instr;
    assign pc         = r_pc;
    assign we_reg     = reset_in && (r_state == S_WB) && we_reg_dec;
    assign full       = r_full;
    assign halted     = (r_state == S_HALT);
    assign ld_reject  = r_rej;

    always_ff @(posedge clka or negedge reset_in) begin
        if (!reset_in) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_load_ptr  <= '0;
            r_instr     <= '0;
            r_full      <= 1'b0;
            r_rej       <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            if (we_ins && (r_full || !w_idle)) begin
                r_rej <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (w_wr) begin
                        // Pointer parks on the last word; full marks it used.
                        if (r_load_ptr == LAST) begin
                            r_full <= 1'b1;
                        end else begin
                            r_load_ptr <= r_load_ptr + 6'd1;
                        end
                    end else if (w_start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= '0;
                        r_load_ptr <= '0;
                        r_full     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_instr <= imem_rdata;
                    if (imem_rdata[15:12] == HALT_OP) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_br_taken  <= br_taken;
                    r_br_target <= br_target;
                    r_state     <= S_WB;
                end
                S_WB: begin
                    if (r_br_taken) begin
                        r_pc <= r_br_target;
                    end else if (r_pc == LAST) begin
                        r_pc <= '0;
                    end else begin
                        r_pc <= r_pc + 6'd1;
                    end
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level reference model plus directed
// load / run / branch / full / reset scenarios.
module tb_cpu_sequencer;

    logic        clka = 1'b0;
    logic        reset_in;
    logic        we_ins;
    logic [15:0] load;
    logic        run;
    logic [15:0] imem_rdata;
    logic        br_taken;
    logic [5:0]  br_target;
    logic        we_reg_dec;
    logic [5:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_we;
    logic [15:0] instr;
    logic [5:0]  pc;
    logic        we_reg;
    logic        full;
    logic        halted;
    logic        ld_reject;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;
    bit watch  = 1'b0;
    int pulses = 0;

    always #5 clka = ~clka;

    cpu_sequencer dut (
        .clka       (clka),
        .reset_in   (reset_in),
        .we_ins     (we_ins),
        .load       (load),
        .run        (run),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .we_reg_dec (we_reg_dec),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .instr      (instr),
        .pc         (pc),
        .we_reg     (we_reg),
        .full       (full),
        .halted     (halted),
        .ld_reject  (ld_reject)
    );

    // Synchronous-read instruction memory seen by the DUT.
    logic [15:0] mem [64];
    always @(posedge clka) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        imem_rdata <= mem[imem_addr];
    end

    // Reference model: busy/halt flags, phase 0..3 within an instruction.
    bit          m_busy, m_halt, m_full, m_rej, m_bt;
    int          m_phase, m_pc, m_lp, m_tgt;
    logic [15:0] m_instr;
    logic [15:0] m_mem [64];

    always @(posedge clka or negedge reset_in) begin
        if (!reset_in) begin
            m_busy = 0; m_halt = 0; m_full = 0; m_rej = 0; m_bt = 0;
            m_phase = 0; m_pc = 0; m_lp = 0; m_tgt = 0; m_instr = 16'h0;
        end else if (!m_busy) begin
            if (we_ins) begin
                if (m_full) m_rej = 1;
                else begin
                    m_mem[m_lp] = load;
                    if (m_lp == 63) m_full = 1;
                    else m_lp = m_lp + 1;
                end
            end else if (run) begin
                m_busy = 1; m_halt = 0; m_phase = 0;
                m_pc = 0; m_lp = 0; m_full = 0;
            end
        end else begin
            if (we_ins) m_rej = 1;
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    m_instr = m_mem[m_pc];
                    if (m_instr[15:12] == 4'hF) begin
                        m_busy = 0; m_halt = 1;
                    end else m_phase = 2;
                end
                2: begin
                    m_bt = br_taken; m_tgt = int'(br_target); m_phase = 3;
                end
                default: begin
                    m_pc = m_bt ? m_tgt : (m_pc + 1) % 64;
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clka) begin
        if (cmp_en) begin
            chk("addr", 32'(imem_addr), m_busy ? m_pc : m_lp);
            chk("mem_we", 32'(imem_we),
                32'(!m_busy && we_ins && !m_full && reset_in));
            chk("wdata", 32'(imem_wdata), 32'(load));
            chk("we_reg", 32'(we_reg),
                32'(m_busy && m_phase == 3 && we_reg_dec && reset_in));
            chk("pc", 32'(pc), m_pc);
            chk("instr", 32'(instr), 32'(m_instr));
            chk("full", 32'(full), 32'(m_full));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("rej", 32'(ld_reject), 32'(m_rej));
        end
    end

    always @(posedge we_reg) if (watch) pulses++;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic wait_model(input int wpc, input int ph, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (m_busy && m_pc == wpc && m_phase == ph) break;
            tick();
        end
        chk("wait_timeout", 32'(m_busy && m_pc == wpc && m_phase == ph), 1);
    endtask

    initial begin
        reset_in = 0; we_ins = 0; load = 0; run = 0;
        br_taken = 0; br_target = 0; we_reg_dec = 0;
        tick();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_halt", 32'(halted), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_rej", 32'(ld_reject), 0);
        chk("rst_wereg", 32'(we_reg), 0);
        tick();
        reset_in = 1;
        cmp_en = 1;

        // Load three words; first cycle also raises run (load wins).
        for (int i = 0; i < 3; i++) begin
            we_ins = 1;
            run = (i == 0);
            load = (i == 0) ? 16'h1234 : (i == 1) ? 16'h5678 : 16'hF000;
            @(negedge clka);
            chk("ld_we", 32'(imem_we), 1);
            chk("ld_addr", 32'(imem_addr), i);
            tick();
            run = 0;
            if (i == 0) chk("sim_idle", 32'(imem_addr), 1);
        end
        we_ins = 0;
        chk("ld_ptr3", 32'(imem_addr), 3);
        chk("ld_nfull", 32'(full), 0);

        run = 1; tick(); run = 0;
        we_reg_dec = 1;
        chk("run_pc0", 32'(pc), 0);
        repeat (4) tick();
        chk("run_pc1", 32'(pc), 1);
        run = 1;
        repeat (4) tick();
        run = 0;
        chk("run_pc2", 32'(pc), 2);
        tick();
        chk("not_yet_halt", 32'(halted), 0);
        tick();
        chk("halted", 32'(halted), 1);
        chk("halt_pc", 32'(pc), 2);
        chk("halt_instr", 32'(instr), 32'h0000F000);

        // Fill all 64 words from HALT, then one extra write.
        for (int i = 0; i < 65; i++) begin
            we_ins = 1;
            load = (i < 64) ? 16'h0100 + 16'(i) : 16'hF0F0;
            @(negedge clka);
            if (i == 64) chk("full_we", 32'(imem_we), 0);
            if (i == 63) chk("full_pre", 32'(full), 0);
            tick();
            if (i == 63) chk("full_set", 32'(full), 1);
        end
        we_ins = 0;
        chk("full_rej", 32'(ld_reject), 1);
        chk("full_addr", 32'(imem_addr), 63);

        run = 1; tick(); run = 0;
        wait_model(5, 2, 40);
        chk("br_pc5", 32'(pc), 5);
        br_taken = 1; br_target = 6'd10;
        tick();
        br_taken = 0; br_target = 0;
        tick();
        chk("br_pc10", 32'(pc), 10);
        wait_model(63, 3, 300);
        tick();
        chk("wrap_pc0", 32'(pc), 0);

        // Asynchronous reset in the middle of EXEC.
        wait_model(3, 2, 40);
        #2;
        watch = 1;
        reset_in = 0;
        #1;
        chk("ar_pc", 32'(pc), 0);
        chk("ar_instr", 32'(instr), 0);
        chk("ar_full", 32'(full), 0);
        chk("ar_rej", 32'(ld_reject), 0);
        chk("ar_halt", 32'(halted), 0);
        chk("ar_addr", 32'(imem_addr), 0);
        chk("ar_wereg", 32'(we_reg), 0);
        chk("ar_memwe", 32'(imem_we), 0);
        repeat (2) tick();
        reset_in = 1;
        repeat (3) tick();
        watch = 0;
        chk("ar_pulses", 32'(pulses), 0);
        chk("ar_idle_pc", 32'(pc), 0);
        we_reg_dec = 0;

        // Load attempt during EXEC is refused and flagged.
        we_ins = 1; load = 16'h2222; tick(); we_ins = 0;
        run = 1; tick(); run = 0;
        wait_model(0, 2, 10);
        we_ins = 1; load = 16'h3333;
        tick();
        we_ins = 0;
        chk("exec_rej", 32'(ld_reject), 1);
        repeat (3) tick();

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
